// File: rtl/dpll_lock_controller.sv
// dpll_lock_controller: DPLL loop sequencer.
// Counts DLF carry/borrow slips over windows of reference edges. Runs the DLF in a
// narrow-K acquisition gear until slip activity stays low, then shifts to a wide-K
// tracking gear and flags lock.
// Optional feature: define DPLL_REF_LOSS_EN to add the reference-loss watchdog.
// Without it, refLost is tied low and REF_TIMEOUT is unused.
module dpll_lock_controller #(
    parameter int unsigned K_ACQ_EXP     = 4,
    parameter int unsigned K_TRK_EXP     = 8,
    parameter int unsigned WINDOW        = 16,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned REF_TIMEOUT   = 4096
) (
    input  logic       oscInput,
    input  logic       reset,
    input  logic       baseClockInput,
    input  logic       dlfCarry,
    input  logic       dlfBorrow,
    output logic [4:0] kExp,
    output logic       dlfEnable,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] slipCount,
    output logic       refLost
);

    localparam int unsigned WinW  = $clog2(WINDOW + 1);
    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

    localparam logic [4:0]       KAcq      = 5'(K_ACQ_EXP);
    localparam logic [4:0]       KTrk      = 5'(K_TRK_EXP);
    localparam logic [WinW-1:0]  WinLast   = WinW'(WINDOW - 1);
    localparam logic [GoodW-1:0] GoodLast  = GoodW'(LOCK_COUNT - 1);
    localparam logic [7:0]       LockThr   = 8'(LOCK_THRESH);
    localparam logic [7:0]       UnlockThr = 8'(UNLOCK_THRESH);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2
    } state_e;

    // Reference synchroniser and edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic ref_edge_q;

    // Measurement and FSM state
    state_e           state_q;
    logic             hold_cnt_q;
    logic [WinW-1:0]  win_q;
    logic [GoodW-1:0] good_q;
    logic [7:0]       acc_q;
    logic [7:0]       slip_q;
    logic [4:0]       kexp_q;
    logic             en_q;
    logic             locked_q;

    logic [8:0] acc_sum;
    logic [7:0] slip_d;
    logic       win_end;
    logic       ref_timeout;

    // Two-flop synchroniser, then a registered rising-edge pulse (3 cycles after the ref edge)
    always_ff @(posedge oscInput or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            ref_edge_q <= 1'b0;
        end else begin
            sync1_q    <= baseClockInput;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            ref_edge_q <= sync2_q & ~sync3_q;
        end
    end

    // Saturating accumulate, including this cycle's slips
    always_comb begin
        acc_sum = {1'b0, acc_q} + {8'd0, dlfCarry} + {8'd0, dlfBorrow};
        slip_d  = acc_sum[8] ? 8'hFF : acc_sum[7:0];
        win_end = ref_edge_q && (win_q == WinLast);
    end

`ifdef DPLL_REF_LOSS_EN
    logic [12:0] wd_q;
    logic        ref_lost_q;

    // Fires on the cycle that completes REF_TIMEOUT cycles without a reference edge
    assign ref_timeout = !ref_lost_q && !ref_edge_q && (wd_q == 13'(REF_TIMEOUT - 1));

    // Watchdog: restarts on every ref edge, freezes once the reference is declared lost
    always_ff @(posedge oscInput or posedge reset) begin
        if (reset) begin
            wd_q       <= 13'd0;
            ref_lost_q <= 1'b0;
        end else if (ref_edge_q) begin
            wd_q       <= 13'd0;
            ref_lost_q <= 1'b0;
        end else if (ref_timeout) begin
            wd_q       <= 13'd0;
            ref_lost_q <= 1'b1;
        end else if (!ref_lost_q) begin
            wd_q       <= wd_q + 13'd1;
        end
    end

    assign refLost = ref_lost_q;
`else
    logic unused_ref_timeout;

    assign unused_ref_timeout = ^REF_TIMEOUT;
    assign ref_timeout        = 1'b0;
    assign refLost            = 1'b0;
`endif

    // Gear-shift FSM with registered outputs and measurement counters
    always_ff @(posedge oscInput or posedge reset) begin
        if (reset) begin
            state_q    <= StHold;
            hold_cnt_q <= 1'b0;
            win_q      <= '0;
            good_q     <= '0;
            acc_q      <= 8'd0;
            slip_q     <= 8'd0;
            kexp_q     <= KAcq;
            en_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else if (ref_timeout) begin
            state_q    <= StHold;
            hold_cnt_q <= 1'b0;
            win_q      <= '0;
            good_q     <= '0;
            acc_q      <= 8'd0;
            kexp_q     <= KAcq;
            en_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                StHold: begin
                    // Slips are ignored until the loop is running
                    acc_q    <= 8'd0;
                    win_q    <= '0;
                    good_q   <= '0;
                    kexp_q   <= KAcq;
                    en_q     <= 1'b0;
                    locked_q <= 1'b0;
                    if (ref_edge_q) begin
                        if (hold_cnt_q) begin
                            state_q    <= StAcquire;
                            hold_cnt_q <= 1'b0;
                            en_q       <= 1'b1;
                        end else begin
                            hold_cnt_q <= 1'b1;
                        end
                    end
                end
                StAcquire, StTrack: begin
                    if (win_end) begin
                        slip_q <= slip_d;
                        acc_q  <= 8'd0;
                        win_q  <= '0;
                        if (state_q == StAcquire) begin
                            if (slip_d <= LockThr) begin
                                if (good_q == GoodLast) begin
                                    state_q  <= StTrack;
                                    kexp_q   <= KTrk;
                                    locked_q <= 1'b1;
                                    good_q   <= '0;
                                end else begin
                                    good_q   <= good_q + GoodW'(1);
                                end
                            end else begin
                                good_q <= '0;
                            end
                        end else if (slip_d > UnlockThr) begin
                            state_q  <= StAcquire;
                            kexp_q   <= KAcq;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                        end
                    end else begin
                        acc_q <= slip_d;
                        if (ref_edge_q) begin
                            win_q <= win_q + WinW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= StHold;
                    kexp_q   <= KAcq;
                    en_q     <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign kExp      = kexp_q;
    assign dlfEnable = en_q;
    assign locked    = locked_q;
    assign state     = state_q;
    assign slipCount = slip_q;

endmodule
